// File: rtl/irq_edge_ctrl_pkg.sv
// Shared constants and sizing helpers for the interrupt edge controller.
package irq_edge_ctrl_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Bits needed to hold a down-counter starting at max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Cycles after reset release during which edge detection is suppressed.
  function automatic int warm_len(input int sync_stages);
    return sync_stages + 1;
  endfunction

endpackage

// File: rtl/irq_edge_chan.sv
// One interrupt channel: synchroniser, edge detect, pending bit and pulse stretcher.
// Stretch counter is built only when IRQ_EDGE_CTRL_STRETCH_EN is defined.
module irq_edge_chan
  import irq_edge_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       irq_in,
  input  logic [1:0] mode,
  input  logic       det_en,
  input  logic       clr,
  output logic       pend,
  output logic       pulse
);

  // sync_pipe[SYNC_STAGES-1] is the synchronised level, sync_pipe[SYNC_STAGES] its previous value.
  logic [SYNC_STAGES:0] sync_pipe, sync_nxt;
  logic s, p, rise_sel, fall_sel, det, pend_nxt;

  assign sync_nxt = {sync_pipe[SYNC_STAGES-1:0], irq_in};

  irq_edge_ctrl_reg #(.W(SYNC_STAGES+1), .RST_VAL('0)) u_sync (
    .clk(clk), .rst_n(rst_n), .d(sync_nxt), .q(sync_pipe)
  );

  assign s        = sync_pipe[SYNC_STAGES-1];
  assign p        = sync_pipe[SYNC_STAGES];
  assign rise_sel = (mode == MODE_RISE) || (mode == MODE_BOTH);
  assign fall_sel = (mode == MODE_FALL) || (mode == MODE_BOTH);
  assign det      = det_en && (mode != MODE_OFF) &&
                    ((rise_sel && s && !p) || (fall_sel && !s && p));

  // A new edge beats a simultaneous clear so no edge is lost.
  assign pend_nxt = det | (pend & ~clr);

  irq_edge_ctrl_reg #(.W(1), .RST_VAL(1'b0)) u_pend (
    .clk(clk), .rst_n(rst_n), .d(pend_nxt), .q(pend)
  );

`ifdef IRQ_EDGE_CTRL_STRETCH_EN
  localparam int CW = cnt_w(STRETCH);
  logic [CW-1:0] cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (det)              cnt_nxt = CW'(STRETCH);
    else if (cnt != '0)   cnt_nxt = cnt - 1'b1;
  end

  irq_edge_ctrl_reg #(.W(CW), .RST_VAL('0)) u_cnt (
    .clk(clk), .rst_n(rst_n), .d(cnt_nxt), .q(cnt)
  );

  assign pulse = |cnt;
`else
  irq_edge_ctrl_reg #(.W(1), .RST_VAL(1'b0)) u_pulse (
    .clk(clk), .rst_n(rst_n), .d(det), .q(pulse)
  );
`endif

endmodule

// File: rtl/irq_edge_ctrl_reg.sv
// Parametrised register primitive: async active-low reset to RST_VAL.
module irq_edge_ctrl_reg #(
  parameter int              W       = 1,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST_VAL;
    else        q <= d;
  end

endmodule

// File: rtl/irq_edge_ctrl.sv
// Multi-channel interrupt edge capture with combined registered irq.
// Define IRQ_EDGE_CTRL_STRETCH_EN to build the STRETCH-cycle pulse counters.
module irq_edge_ctrl
  import irq_edge_ctrl_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH     = 8
) (
  input  logic             cpu_clk,
  input  logic             cpu_resetn,
  input  logic [NCH-1:0]   irq_in,
  input  logic [2*NCH-1:0] mode,
  input  logic [NCH-1:0]   en,
  input  logic             clr_valid,
  input  logic [NCH-1:0]   clr_mask,
  output logic [NCH-1:0]   pend,
  output logic [NCH-1:0]   pulse,
  output logic             irq
);

  localparam int WARM = warm_len(SYNC_STAGES);
  localparam int WW   = cnt_w(WARM);

  logic [WW-1:0] warm_cnt, warm_nxt;
  logic          det_en, irq_nxt;

  // Saturating warm-up counter keeps reset-time sync garbage from looking like an edge.
  assign det_en   = (warm_cnt == WW'(WARM));
  assign warm_nxt = det_en ? warm_cnt : warm_cnt + 1'b1;

  irq_edge_ctrl_reg #(.W(WW), .RST_VAL('0)) u_warm (
    .clk(cpu_clk), .rst_n(cpu_resetn), .d(warm_nxt), .q(warm_cnt)
  );

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    irq_edge_chan #(.SYNC_STAGES(SYNC_STAGES), .STRETCH(STRETCH)) u_chan (
      .clk   (cpu_clk),
      .rst_n (cpu_resetn),
      .irq_in(irq_in[i]),
      .mode  (mode[2*i +: 2]),
      .det_en(det_en),
      .clr   (clr_valid & clr_mask[i]),
      .pend  (pend[i]),
      .pulse (pulse[i])
    );
  end

  assign irq_nxt = |(pend & en);

  irq_edge_ctrl_reg #(.W(1), .RST_VAL(1'b0)) u_irq (
    .clk(cpu_clk), .rst_n(cpu_resetn), .d(irq_nxt), .q(irq)
  );

endmodule

// File: tb/tb_irq_edge_ctrl.sv
// Directed bench for irq_edge_ctrl (NCH=4, SYNC_STAGES=2, STRETCH=8).
module tb_irq_edge_ctrl;

  localparam int NCH = 4;
  localparam int SYNC_STAGES = 2;
  localparam int STRETCH = 8;
`ifdef IRQ_EDGE_CTRL_STRETCH_EN
  localparam int PW = STRETCH;
`else
  localparam int PW = 1;
`endif

  logic             cpu_clk = 1'b0;
  logic             cpu_resetn;
  logic [NCH-1:0]   irq_in;
  logic [2*NCH-1:0] mode;
  logic [NCH-1:0]   en;
  logic             clr_valid;
  logic [NCH-1:0]   clr_mask;
  logic [NCH-1:0]   pend;
  logic [NCH-1:0]   pulse;
  logic             irq;

  int checks = 0;
  int fails  = 0;

  irq_edge_ctrl #(.NCH(NCH), .SYNC_STAGES(SYNC_STAGES), .STRETCH(STRETCH)) dut (
    .cpu_clk(cpu_clk), .cpu_resetn(cpu_resetn), .irq_in(irq_in), .mode(mode),
    .en(en), .clr_valid(clr_valid), .clr_mask(clr_mask),
    .pend(pend), .pulse(pulse), .irq(irq)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic clear(input logic [NCH-1:0] m);
    clr_valid = 1'b1;
    clr_mask  = m;
    step();
    clr_valid = 1'b0;
    clr_mask  = '0;
  endtask

  logic [19:0] p0_h, pd0_h, irq_h, p1_h, pd1_h, p2_h, pd2_h;

  initial begin
    cpu_resetn = 1'b0;
    irq_in     = 4'b0001;
    mode       = 8'b01_01_01_01;
    en         = 4'hF;
    clr_valid  = 1'b0;
    clr_mask   = '0;

    // reset and warm-up with ch0 held high
    repeat (3) step();
    chk("rst_pend", 32'(pend), 0);
    chk("rst_pulse", 32'(pulse), 0);
    chk("rst_irq", 32'(irq), 0);
    cpu_resetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("warm_pend", 32'(pend), 0);
      chk("warm_pulse", 32'(pulse), 0);
      chk("warm_irq", 32'(irq), 0);
    end

    // ch0 rise, ch1 fall, ch2 both, ch3 rise
    mode = 8'b01_11_10_01;
    irq_in[0] = 1'b0;
    repeat (4) step();
    chk("fall_in_rise_mode", 32'(pend), 0);
    irq_in[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      p0_h[k] = pulse[0]; pd0_h[k] = pend[0]; irq_h[k] = irq;
    end
    chk("rise_pend_e1", 32'(pd0_h[1]), 0);
    chk("rise_pend_e2", 32'(pd0_h[2]), 1);
    chk("rise_irq_e2", 32'(irq_h[2]), 0);
    chk("rise_irq_e3", 32'(irq_h[3]), 1);
    chk("rise_pulse_e1", 32'(p0_h[1]), 0);
    chk("rise_pulse_e2", 32'(p0_h[2]), 1);
    chk("rise_pulse_last", 32'(p0_h[2+PW-1]), 1);
    chk("rise_pulse_end", 32'(p0_h[2+PW]), 0);
    chk("rise_pulse_len", 32'($countones(p0_h)), PW);

    clear(4'b0001);
    chk("clr_pend", 32'(pend), 0);
    chk("clr_irq_lag", 32'(irq), 1);
    step();
    chk("clr_irq", 32'(irq), 0);

    // 4-cycle high pulse on ch1 (fall mode) and ch2 (both modes)
    irq_in[2:1] = 2'b11;
    for (int k = 0; k < 20; k++) begin
      if (k == 4) irq_in[2:1] = 2'b00;
      step();
      p1_h[k] = pulse[1]; pd1_h[k] = pend[1];
      p2_h[k] = pulse[2]; pd2_h[k] = pend[2];
    end
    chk("fall_pend_e2", 32'(pd1_h[2]), 0);
    chk("fall_pend_e5", 32'(pd1_h[5]), 0);
    chk("fall_pend_e6", 32'(pd1_h[6]), 1);
    chk("fall_pulse_e6", 32'(p1_h[6]), 1);
    chk("fall_pulse_len", 32'($countones(p1_h)), PW);
    chk("both_pend_e2", 32'(pd2_h[2]), 1);
    chk("both_pulse_e2", 32'(p2_h[2]), 1);
    chk("both_pulse_e6", 32'(p2_h[6]), 1);
    chk("both_pulse_last", 32'(p2_h[6+PW-1]), 1);
    chk("both_pulse_end", 32'(p2_h[6+PW]), 0);
    chk("both_pulse_len", 32'($countones(p2_h)), (PW >= 4) ? 4 + PW : 2 * PW);
    clear(4'b0110);
    chk("clr12_pend", 32'(pend), 0);
    step();

    // clear in the same cycle det[0] fires
    irq_in[0] = 1'b0;
    repeat (4) step();
    irq_in[0] = 1'b1;
    step();
    step();
    clear(4'b0001);
    chk("race_set_wins", 32'(pend[0]), 1);
    clear(4'b0001);
    chk("race_clr2_pend", 32'(pend[0]), 0);
    chk("race_clr2_irq_lag", 32'(irq), 1);
    step();
    chk("race_clr2_irq", 32'(irq), 0);

    // ch3 masked from irq
    en = 4'b0111;
    irq_in[3] = 1'b1;
    repeat (4) step();
    chk("mask_pend3", 32'(pend), 32'h8);
    chk("mask_irq", 32'(irq), 0);
    clear(4'b1000);
    // ch3 mode off
    mode[7:6] = 2'b00;
    irq_in[3] = 1'b0;
    repeat (3) step();
    irq_in[3] = 1'b1;
    repeat (4) step();
    chk("off_pend", 32'(pend), 0);
    chk("off_pulse3", 32'(pulse[3]), 0);

    // reset four cycles into a pulse
    irq_in[0] = 1'b0;
    repeat (4) step();
    irq_in[0] = 1'b1;
    repeat (6) step();
    chk("mid_pend", 32'(pend[0]), 1);
    chk("mid_pulse", 32'(pulse[0]), (PW >= 4) ? 1 : 0);
    cpu_resetn = 1'b0;
    #1;
    chk("mid_rst_pend", 32'(pend), 0);
    chk("mid_rst_pulse", 32'(pulse), 0);
    chk("mid_rst_irq", 32'(irq), 0);
    repeat (2) step();
    cpu_resetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rewarm_pend", 32'(pend), 0);
      chk("rewarm_pulse", 32'(pulse), 0);
      chk("rewarm_irq", 32'(irq), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/irq_edge_ctrl.md
# irq_edge_ctrl

Multi-channel interrupt edge capture and pulse stretcher in the `cpu_clk` domain. It synchronises `NCH` asynchronous interrupt lines and detects rising, falling or both edges per channel. Each detected edge latches a software-clearable pending bit and produces a fixed-length stretched pulse. It sits between device interrupt sources (ethernet and others) and the CPU interrupt input, and drives one combined, registered `irq`.

## Interface
Parameters:
- `NCH`, 4: number of interrupt channels, 1..32.
- `SYNC_STAGES`, 2: synchroniser flops per channel, ≥2.
- `STRETCH`, 8: stretched pulse length in `cpu_clk` cycles, 1..255.

Ports (one clock; reset is asynchronous and active-low):
- `cpu_clk`  in  1  block clock.
- `cpu_resetn`  in  1  asynchronous active-low reset.
- `irq_in`  in  NCH  asynchronous interrupt sources.
- `mode`  in  2*NCH  per-channel edge select at bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
- `en`  in  NCH  per-channel enable into `irq`.
- `clr_valid`  in  1  clear strobe, sampled each cycle.
- `clr_mask`  in  NCH  pending bits to clear when `clr_valid`=1.
- `pend`  out  NCH  pending bits.
- `pulse`  out  NCH  stretched per-channel edge pulses.
- `irq`  out  1  registered OR of `pend & en`.

## Operation
- Sync chain per channel. Reset value 0. Stage 0 samples `irq_in[i]`. `s` is the last stage, and `p` is `s` delayed by one cycle.
- Edge detect `det[i]` is combinational:
  - rise when `s & !p`;
  - fall when `!s & p`;
  - gated by `mode[i]`.
  - Mode 00 never detects. A mode change takes effect in the cycle it is applied.
- Warm-up: a counter suppresses `det` for the first `SYNC_STAGES+1` cycles after reset release. A line held high through reset therefore reports no edge.
- Pending:
  - `det[i]` sets `pend[i]`.
  - `clr_valid & clr_mask[i]` clears it.
  - If set and clear happen in the same cycle, set wins. No edge is lost.
  - `pend` is independent of `en`.
- Pulse, per-channel down-counter of width clog2(`STRETCH`+1):
  - `det` loads the counter and raises `pulse`.
  - `pulse` stays high for exactly `STRETCH` consecutive cycles.
  - A `det` while `pulse` is high reloads the counter, so `pulse` stays high for `STRETCH` cycles after the retriggering edge.
  - The counter never wraps. It holds at 0.
- `irq` is registered from `|(pend & en)`.
- Outputs after reset: `pend`=0, `pulse`=0, `irq`=0, counters=0.
- Reset assertion mid-operation clears all state immediately, including sync flops, counters and the warm-up counter.

## Timing
- Reference point: `irq_in[i]` toggles before edge 0, with setup met.
  - `det` is high in the cycle after edge `SYNC_STAGES-1`.
  - `pend` and `pulse` are high after edge `SYNC_STAGES`.
  - `irq` is high after edge `SYNC_STAGES+1`.
- Clear latency: `pend` is low the cycle after the `clr_valid` edge. `irq` falls one cycle later.
- Input pulse width: guaranteed capture requires an `irq_in` level held for at least 2 `cpu_clk` cycles. Shorter glitches may be missed.
- Back-to-back edges: edges on consecutive cycles each assert `det` in their own cycle. `pend` stays set.

## Configuration
- `IRQ_EDGE_CTRL_STRETCH_EN` defined: pulse counters are built and behave as above.
- `IRQ_EDGE_CTRL_STRETCH_EN` undefined:
  - `pulse[i]` is the registered `det[i]`, exactly one cycle wide.
  - No counters are instantiated, and `STRETCH` is ignored.
  - `pend` and `irq` behaviour is unchanged.

## Structure
- `irq_edge_ctrl_pkg` holds:
  - localparams `MODE_OFF`, `MODE_RISE`, `MODE_FALL` and `MODE_BOTH`;
  - the counter-width function;
  - the warm-up length function.
- Sub-module `irq_edge_chan` handles one channel: sync chain, edge detect, pending and stretch counter. It is instantiated `NCH` times by generate.
- The top level holds the shared warm-up counter, the `irq` OR and the `irq` register.
- All state lives in the team's parametrised register primitive, with reset value as a parameter.

## Test plan
- Reset warm-up: hold `irq_in`=4'b0001, `mode`=all rise, release reset. Expect `pend`=0, `pulse`=0 and `irq`=0 throughout, and no edge reported.
- Rising edge on ch0 with `en`=1, `STRETCH`=8, `SYNC_STAGES`=2:
  - `pend[0]` is 1 after edge 2 and `irq` is 1 after edge 3;
  - `pulse[0]` is high for exactly 8 cycles.
- Falling and both modes: ch1 in mode 10 gets a 0→1→0 pulse of 4 cycles and sets `pend[1]` only on the fall. ch2 in mode 11 sees the same stimulus, so `pulse[2]` is retriggered on the fall and stays high 8 cycles after it.
- Clear-versus-set race: assert `clr_valid` with `clr_mask`=4'b0001 in the same cycle `det[0]`=1. `pend[0]` must stay 1. A second clear with no edge makes `pend[0]` 0 and `irq` 0 one cycle later.
- Mask and mode off:
  - ch3 with `en[3]`=0 gets an edge: `pend[3]`=1 and `irq`=0.
  - ch3 with `mode`=00 gets an edge: `pend[3]` unchanged.
- Reset mid-pulse: assert `cpu_resetn`=0 four cycles into a stretched pulse. All outputs are 0 immediately and stay 0 through warm-up after release. With the macro undefined, rerun the rising-edge test and expect `pulse[0]` to be exactly 1 cycle wide.
